// File: rtl/conware_pkg.sv
// Shared definitions for the Game-of-Life compute engine: FSM state encoding,
// the birth/survival neighbour counts, and the flat-grid bit index helper.
package conware_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] BIRTH_COUNT = 4'd3;
    localparam logic [3:0] SURVIVE_LO  = 4'd2;
    localparam logic [3:0] SURVIVE_HI  = 4'd3;

    // Cell (x,y) lives at bit y*width+x (raster order).
    function automatic int bit_idx(input int x, input int y, input int width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/conware_cell_rule.sv
// Combinational Life rule for one cell.
// Ports:
//   alive_i  current state of the cell
//   nbr_i    the 8 neighbour states (already forced to 0 where off-grid)
//   alive_o  state of the cell in the next generation
module conware_cell_rule
    import conware_pkg::*;
(
    input  logic       alive_i,
    input  logic [7:0] nbr_i,
    output logic       alive_o
);

    logic [3:0] n;

    always_comb begin
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nbr_i[i]};
        end
        alive_o = (n == BIRTH_COUNT) ||
                  (alive_i && (n >= SURVIVE_LO) && (n <= SURVIVE_HI));
    end

endmodule

// File: rtl/conware_life_engine.sv
// Game-of-Life engine: accepts a WIDTH x HEIGHT grid, computes the next
// generation one row per cycle, and offers it downstream.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_data/valid/ready    input grid handshake (accepted only in IDLE)
//   out_data/valid/ready   next-generation handshake (valid in DONE)
//   gen_count              number of completed output handshakes
module conware_life_engine
    import conware_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int TORUS  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*HEIGHT-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH*HEIGHT-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             gen_count
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int RW = $clog2(HEIGHT);

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [N-1:0]      cur_q, cur_d;
    logic [N-1:0]      nxt_q, nxt_d;
    logic [31:0]       gen_q, gen_d;

    logic [WIDTH-1:0]  row_up, row_mid, row_dn, row_new;

    // Rows above/below the one being computed; off-grid rows are dead unless
    // wrapping, in which case they come from the opposite edge.
    always_comb begin
        row_mid = cur_q[bit_idx(0, int'(row_q), WIDTH) +: WIDTH];
        if (int'(row_q) == 0) begin
            row_up = (TORUS != 0) ? cur_q[bit_idx(0, HEIGHT-1, WIDTH) +: WIDTH] : '0;
        end else begin
            row_up = cur_q[bit_idx(0, int'(row_q) - 1, WIDTH) +: WIDTH];
        end
        if (int'(row_q) == HEIGHT-1) begin
            row_dn = (TORUS != 0) ? cur_q[bit_idx(0, 0, WIDTH) +: WIDTH] : '0;
        end else begin
            row_dn = cur_q[bit_idx(0, int'(row_q) + 1, WIDTH) +: WIDTH];
        end
    end

    for (genvar x = 0; x < WIDTH; x++) begin : g_col
        // Column neighbours are resolved at elaboration time.
        localparam int XL = (x == 0) ? WIDTH-1 : x-1;
        localparam int XR = (x == WIDTH-1) ? 0 : x+1;
        localparam bit HAS_L = (x != 0) || (TORUS != 0);
        localparam bit HAS_R = (x != WIDTH-1) || (TORUS != 0);

        logic [7:0] nbr;

        assign nbr = {HAS_L ? row_up[XL]  : 1'b0, row_up[x],
                      HAS_R ? row_up[XR]  : 1'b0,
                      HAS_L ? row_mid[XL] : 1'b0,
                      HAS_R ? row_mid[XR] : 1'b0,
                      HAS_L ? row_dn[XL]  : 1'b0, row_dn[x],
                      HAS_R ? row_dn[XR]  : 1'b0};

        conware_cell_rule u_rule (
            .alive_i (row_mid[x]),
            .nbr_i   (nbr),
            .alive_o (row_new[x])
        );
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = nxt_q;
    assign gen_count = gen_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        gen_d   = gen_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cur_d   = in_data;
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                nxt_d[bit_idx(0, int'(row_q), WIDTH) +: WIDTH] = row_new;
                if (row_q == RW'(HEIGHT-1)) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    gen_d   = gen_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            gen_q   <= gen_d;
        end
    end

endmodule

// File: tb/tb_conware_life_engine.sv
module tb_conware_life_engine;

    localparam int W = 4;
    localparam int H = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W*H-1:0] in_data;
    logic          in_valid;
    logic          out_ready;

    logic [W*H-1:0] out_data0, out_data1;
    logic          out_valid0, out_valid1;
    logic          in_ready0, in_ready1;
    logic [31:0]   gen0, gen1;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_gen = 0;

    always #5 clk = ~clk;

    conware_life_engine #(.WIDTH(W), .HEIGHT(H), .TORUS(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .gen_count(gen0)
    );

    conware_life_engine #(.WIDTH(W), .HEIGHT(H), .TORUS(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .gen_count(gen1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: apply Life directly on a 2-D view of the grid.
    function automatic logic [W*H-1:0] life_ref(input logic [W*H-1:0] g, input int torus);
        logic [W*H-1:0] r;
        int n, xx, yy;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        xx = x + dx;
                        yy = y + dy;
                        if (torus != 0) begin
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                        end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
                            continue;
                        end
                        n += int'(g[yy*W + xx]);
                    end
                end
                r[y*W + x] = (n == 3) || (g[y*W + x] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic run_gen(input logic [W*H-1:0] g, input logic [W*H-1:0] e0,
                           input logic [W*H-1:0] e1, input string name, input int stall);
        int cyc;
        logic [W*H-1:0] held;
        cyc = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1) && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " in_ready"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
        in_data  = g;
        in_valid = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!out_valid0 && cyc < 30) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(H));
        check({name, " out_valid1"}, {31'd0, out_valid1}, 32'd1);
        in_valid = 1'b1;
        in_data  = ~g;
        held = out_data0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, " stall valid"}, {31'd0, out_valid0}, 32'd1);
            check({name, " stall data"}, 32'(out_data0), 32'(held));
            check({name, " stall in_ready"}, {31'd0, in_ready0}, 32'd0);
            check({name, " stall gen"}, gen0, exp_gen);
        end
        check({name, " data t0"}, 32'(out_data0), 32'(e0));
        check({name, " data t1"}, 32'(out_data1), 32'(e1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_gen   = exp_gen + 32'd1;
        check({name, " gen t0"}, gen0, exp_gen);
        check({name, " gen t1"}, gen1, exp_gen);
        check({name, " in_ready after"}, {31'd0, in_ready0}, 32'd1);
        check({name, " out_valid after"}, {31'd0, out_valid0}, 32'd0);
    endtask

    typedef struct {
        logic [W*H-1:0] grid;
        logic [W*H-1:0] exp0;
        logic [W*H-1:0] exp1;
        string          name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W*H-1:0] g;
        int cyc;

        vecs[0] = '{16'h0222, 16'h0070, 16'h0070, "blinker_v"};
        vecs[1] = '{16'h0070, 16'h0222, 16'h0222, "blinker_h"};
        vecs[2] = '{16'h0660, 16'h0660, 16'h0660, "block"};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, "empty"};
        vecs[4] = '{16'h000B, 16'h0000, 16'h1011, "wrap"};
        vecs[5] = '{16'hFFFF, 16'h9009, 16'h0000, "full"};

        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready0}, 32'd0);
        check("reset out_valid", {31'd0, out_valid0}, 32'd0);
        check("reset gen", gen0, 32'd0);
        check("reset out_data", 32'(out_data0), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_gen(vecs[i].grid, vecs[i].exp0, vecs[i].exp1, vecs[i].name, 0);
        end

        run_gen(16'h0660, 16'h0660, 16'h0660, "backpressure", 10);

        // Reset two cycles after accept.
        cyc = 0;
        @(negedge clk);
        while (!in_ready0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        in_data  = 16'h0222;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_gen = 32'd0;
        check("rst mid out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst mid in_ready", {31'd0, in_ready0}, 32'd0);
        check("rst mid gen", gen0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst in_ready", {31'd0, in_ready0}, 32'd1);
        check("post rst out_valid", {31'd0, out_valid0}, 32'd0);
        run_gen(16'h0222, 16'h0070, 16'h0070, "post_rst", 0);

        for (int i = 0; i < 20; i++) begin
            g = 16'($urandom);
            run_gen(g, life_ref(g, 0), life_ref(g, 1), "random", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
